// File: rtl/led_blink_seq.sv
// Programmable LED blink sequencer: N blinks with ON/OFF durations in prescaled ticks,
// start/busy/done handshake and abort. All outputs come straight from flops.
module led_blink_seq #(
    parameter int CLK_DIV     = 100000,
    parameter int TIME_WIDTH  = 16,
    parameter int COUNT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [TIME_WIDTH-1:0]  on_time,
    input  logic [TIME_WIDTH-1:0]  off_time,
    input  logic [COUNT_WIDTH-1:0] num_blinks,
    output logic                   LED,
    output logic                   busy,
    output logic                   done,
    output logic [COUNT_WIDTH-1:0] blinks_left
);

    localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [PW-1:0]          presc, presc_nxt;
    logic [TIME_WIDTH-1:0]  ticks, ticks_nxt;
    logic [TIME_WIDTH-1:0]  cfg_on, cfg_on_nxt;
    logic [TIME_WIDTH-1:0]  cfg_off, cfg_off_nxt;
    logic                   led_nxt, busy_nxt, done_nxt;
    logic [COUNT_WIDTH-1:0] blinks_left_nxt;
    logic                   wrap, phase_end;

    // A zero duration would give an empty phase; stretch it to one tick.
    function automatic logic [TIME_WIDTH-1:0] eff_dur(input logic [TIME_WIDTH-1:0] d);
        return (d == '0) ? TIME_WIDTH'(1) : d;
    endfunction

    assign wrap      = (presc == PRESC_MAX);
    assign phase_end = wrap && (ticks == TIME_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            presc       <= '0;
            ticks       <= '0;
            cfg_on      <= '0;
            cfg_off     <= '0;
            LED         <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            blinks_left <= '0;
        end else begin
            state       <= state_nxt;
            presc       <= presc_nxt;
            ticks       <= ticks_nxt;
            cfg_on      <= cfg_on_nxt;
            cfg_off     <= cfg_off_nxt;
            LED         <= led_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
            blinks_left <= blinks_left_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        presc_nxt       = presc;
        ticks_nxt       = ticks;
        cfg_on_nxt      = cfg_on;
        cfg_off_nxt     = cfg_off;
        led_nxt         = LED;
        busy_nxt        = busy;
        done_nxt        = 1'b0;
        blinks_left_nxt = blinks_left;

        case (state)
            S_IDLE: begin
                presc_nxt = '0;
                ticks_nxt = '0;
                if (start && !abort) begin
                    cfg_on_nxt  = eff_dur(on_time);
                    cfg_off_nxt = eff_dur(off_time);
                    if (num_blinks == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt       = S_ON;
                        ticks_nxt       = eff_dur(on_time);
                        led_nxt         = 1'b1;
                        busy_nxt        = 1'b1;
                        blinks_left_nxt = num_blinks;
                    end
                end
            end

            S_ON: begin
                // Prescaler restarts on every phase change so phase lengths are exact.
                presc_nxt = wrap ? '0 : presc + PW'(1);
                if (wrap) ticks_nxt = ticks - TIME_WIDTH'(1);
                if (phase_end) begin
                    led_nxt = 1'b0;
                    if (blinks_left == COUNT_WIDTH'(1)) begin
                        state_nxt       = S_IDLE;
                        ticks_nxt       = '0;
                        busy_nxt        = 1'b0;
                        done_nxt        = 1'b1;
                        blinks_left_nxt = '0;
                    end else begin
                        state_nxt       = S_OFF;
                        ticks_nxt       = cfg_off;
                        blinks_left_nxt = blinks_left - COUNT_WIDTH'(1);
                    end
                end
            end

            S_OFF: begin
                presc_nxt = wrap ? '0 : presc + PW'(1);
                if (wrap) ticks_nxt = ticks - TIME_WIDTH'(1);
                if (phase_end) begin
                    state_nxt = S_ON;
                    ticks_nxt = cfg_on;
                    led_nxt   = 1'b1;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                presc_nxt = '0;
                ticks_nxt = '0;
                led_nxt   = 1'b0;
                busy_nxt  = 1'b0;
            end
        endcase

        // Abort wins over everything, but only matters once a sequence is running.
        if (abort && state != S_IDLE) begin
            state_nxt       = S_IDLE;
            presc_nxt       = '0;
            ticks_nxt       = '0;
            led_nxt         = 1'b0;
            busy_nxt        = 1'b0;
            done_nxt        = 1'b0;
            blinks_left_nxt = '0;
        end
    end

endmodule

// File: tb/tb_led_blink_seq.sv
// Scoreboard bench for led_blink_seq: the stimulus side predicts every output change
// from the blink arithmetic; a negedge monitor pops and compares on each observed change.
module tb_led_blink_seq;

    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] on_time = '0;
    logic [15:0] off_time = '0;
    logic [7:0]  num_blinks = '0;
    logic        led, busy, done;
    logic [7:0]  blinks_left;

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    typedef struct {
        int         t;
        logic       led;
        logic       busy;
        logic       done;
        logic [7:0] bl;
    } ev_t;

    ev_t exp_q[$];
    ev_t mon_last = '{0, 1'b0, 1'b0, 1'b0, 8'd0};

    led_blink_seq #(.CLK_DIV(D), .TIME_WIDTH(16), .COUNT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .on_time(on_time), .off_time(off_time), .num_blinks(num_blinks),
        .LED(led), .busy(busy), .done(done), .blinks_left(blinks_left)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic ev_t mk(input int t, input logic l, input logic b, input logic d,
                               input logic [7:0] n);
        ev_t e;
        e.t = t; e.led = l; e.busy = b; e.done = d; e.bl = n;
        return e;
    endfunction

    // Predict the full trace of a sequence whose start is sampled on edge s.
    task automatic launch(input int s, input int on, input int off, input int num,
                          output int end_t);
        int ton, toff, t;
        ton  = ((on == 0) ? 1 : on) * D;
        toff = ((off == 0) ? 1 : off) * D;
        if (exp_q.size() > 0 && exp_q[$].t == s && !exp_q[$].led && !exp_q[$].busy &&
            !exp_q[$].done && exp_q[$].bl == 0)
            void'(exp_q.pop_back());
        if (num == 0) begin
            exp_q.push_back(mk(s, 0, 0, 1, 0));
            exp_q.push_back(mk(s + 1, 0, 0, 0, 0));
            end_t = s;
            return;
        end
        t = s;
        for (int i = num; i >= 1; i--) begin
            exp_q.push_back(mk(t, 1, 1, 0, 8'(i)));
            t += ton;
            if (i == 1) begin
                exp_q.push_back(mk(t, 0, 0, 1, 0));
                exp_q.push_back(mk(t + 1, 0, 0, 0, 0));
            end else begin
                exp_q.push_back(mk(t, 0, 1, 0, 8'(i - 1)));
                t += toff;
            end
        end
        end_t = t;
    endtask

    // Everything from edge a on is replaced by the idle state (abort or reset).
    task automatic cut(input int a);
        ev_t r;
        while (exp_q.size() > 0 && exp_q[$].t >= a) void'(exp_q.pop_back());
        r = (exp_q.size() > 0) ? exp_q[$] : mon_last;
        if (r.led || r.busy || r.done || r.bl != 0) exp_q.push_back(mk(a, 0, 0, 0, 0));
    endtask

    initial begin : monitor
        ev_t prev, cur, e;
        prev = mk(0, 0, 0, 0, 0);
        forever begin
            @(negedge clk);
            cur = mk(cyc, led, busy, done, blinks_left);
            if (cur.led != prev.led || cur.busy != prev.busy || cur.done != prev.done ||
                cur.bl != prev.bl) begin
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_change: got t=%0d led=%0b busy=%0b done=%0b bl=%0d, expected no change",
                             cur.t, cur.led, cur.busy, cur.done, cur.bl);
                end else begin
                    e = exp_q.pop_front();
                    mon_last = e;
                    if (e.t != cur.t || e.led != cur.led || e.busy != cur.busy ||
                        e.done != cur.done || e.bl != cur.bl) begin
                        mismatched++;
                        $display("FAIL event: got t=%0d led=%0b busy=%0b done=%0b bl=%0d, expected t=%0d led=%0b busy=%0b done=%0b bl=%0d",
                                 cur.t, cur.led, cur.busy, cur.done, cur.bl,
                                 e.t, e.led, e.busy, e.done, e.bl);
                    end
                end
            end
            prev = cur;
        end
    end

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got != want) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() > 0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("drain_pending_events", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Called at a negedge; drives start now. Returns at a negedge: the done cycle,
    // or the cycle after the abort edge.
    task automatic do_seq(input int on, input int off, input int num, input int abort_rel,
                          input bit noise, output int end_t);
        int s, stop;
        start = 1'b1; on_time = 16'(on); off_time = 16'(off); num_blinks = 8'(num);
        s = cyc + 1;
        launch(s, on, off, num, end_t);
        stop = (abort_rel > 0) ? s + abort_rel - 1 : end_t;
        @(negedge clk);
        start = 1'b0;
        while (cyc < stop) begin
            if (noise) begin
                start      = ($urandom_range(3) == 0);
                on_time    = 16'($urandom_range(9));
                off_time   = 16'($urandom_range(9));
                num_blinks = 8'($urandom_range(9));
            end
            @(negedge clk);
        end
        start = 1'b0;
        if (abort_rel > 0) begin
            abort = 1'b1;
            cut(s + abort_rel);
            @(negedge clk);
            abort = 1'b0;
            end_t = s + abort_rel;
        end
    endtask

    initial begin : stim
        int e, c, on, off, num, len, ab;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_led", int'(led), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_blinks_left", int'(blinks_left), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic sequence and zero cases
        do_seq(3, 2, 3, 0, 0, e);
        repeat (3) @(negedge clk);
        do_seq(5, 5, 0, 0, 0, e);
        repeat (3) @(negedge clk);
        do_seq(0, 0, 2, 0, 0, e);
        drain();

        // inputs ignored while busy, then start in the done cycle
        @(negedge clk);
        do_seq(3, 2, 2, 0, 1, e);
        do_seq(1, 1, 1, 0, 0, e);
        drain();

        // abort in second OFF phase; abort+start together in idle
        @(negedge clk);
        do_seq(3, 2, 3, 34, 0, e);
        repeat (5) @(negedge clk);
        start = 1'b1; abort = 1'b1; on_time = 16'd2; num_blinks = 8'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        repeat (20) @(negedge clk);
        drain();

        // asynchronous reset while the LED is on
        start = 1'b1; on_time = 16'd3; off_time = 16'd2; num_blinks = 8'd3;
        launch(cyc + 1, 3, 2, 3, e);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        c = cyc;
        cut(c);
        #1;
        check("async_reset_led", int'(led), 0);
        check("async_reset_busy", int'(busy), 0);
        check("async_reset_blinks_left", int'(blinks_left), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        drain();

        // randomized sequences with noise, occasional abort and back-to-back starts
        for (int i = 0; i < 25; i++) begin
            on  = $urandom_range(4);
            off = $urandom_range(4);
            num = $urandom_range(4);
            len = (num == 0) ? 0 :
                  num * ((on == 0) ? 1 : on) * D + (num - 1) * ((off == 0) ? 1 : off) * D;
            ab  = (len > 0 && $urandom_range(3) == 0) ? 1 + int'($urandom_range(len - 1)) : 0;
            do_seq(on, off, num, ab, 1, e);
            repeat ($urandom_range(3)) @(negedge clk);
        end
        repeat (5) @(negedge clk);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
